fir_datapath: RTL and testbench

FIR_DATAPATH -- requirements
Module: fir_datapath

---
 rtl/fir_pkg.sv | 35 +++
 rtl/fir_alu.sv | 59 +++++
 rtl/fir_datapath.sv | 70 +++++++
 tb/tb_fir_datapath.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared types and constants for the FIR datapath
// Saturation option (FIR_DATAPATH_SATURATE_EN) lives in fir_alu.
package fir_pkg;

   localparam int REG_W    = 17;
   localparam int NUM_REGS = 16;
   localparam int MSB      = REG_W - 1;

   typedef enum logic [2:0] {
      OP_NOP   = 3'b000,
      OP_COPY  = 3'b001,
      OP_LOAD1 = 3'b010,
      OP_LOAD2 = 3'b011,
      OP_ADD   = 3'b100,
      OP_SUB   = 3'b101,
      OP_MUL   = 3'b110,
      OP_RSVD  = 3'b111
   } op_e;

   typedef logic [3:0] reg_idx_t;
   typedef logic signed [REG_W-1:0] reg_word_t;
   typedef logic signed [2*REG_W-1:0] prod_t;

   // Clamp limits of the 17-bit signed range.
   localparam reg_word_t SAT_MAX = 17'sh0FFFF;
   localparam reg_word_t SAT_MIN = 17'sh10000;

   // Q15 scaling applied to products.
   localparam int FRAC_BITS = 15;

   function automatic logic is_arith(input op_e op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL);
   endfunction

endpackage

// File: rtl/fir_alu.sv
// rtl/fir_alu.sv - combinational ADD/SUB/MUL with overflow detection
// Define FIR_DATAPATH_SATURATE_EN to clamp overflowing results instead of wrapping.
module fir_alu
   import fir_pkg::*;
(
   input  op_e       op,
   input  reg_word_t a,
   input  reg_word_t b,
   output reg_word_t result,
   output logic      overflow
);

   reg_word_t sum;
   reg_word_t diff;
   prod_t     prod;
   prod_t     shifted;
   reg_word_t raw;
   logic      ovf;

   always_comb begin
      sum     = a + b;
      diff    = a - b;
      prod    = a * b;
      shifted = prod >>> FRAC_BITS;
      raw     = '0;
      ovf     = 1'b0;
      case (op)
         OP_ADD: begin
            raw = sum;
            ovf = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
         end
         OP_SUB: begin
            // a and -b share a sign exactly when a and b differ in sign.
            raw = diff;
            ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
         end
         OP_MUL: begin
            raw = shifted[MSB:0];
            ovf = shifted[2*REG_W-1:MSB] != {(REG_W+1){shifted[MSB]}};
         end
         default: begin
            raw = '0;
            ovf = 1'b0;
         end
      endcase
   end

   assign overflow = ovf;

`ifdef FIR_DATAPATH_SATURATE_EN
   // On ADD/SUB overflow the true result carries the sign of a.
   logic neg;
   assign neg    = (op == OP_MUL) ? shifted[2*REG_W-1] : a[MSB];
   assign result = ovf ? (neg ? SAT_MIN : SAT_MAX) : raw;
`else
   assign result = raw;
`endif

endmodule

// File: rtl/fir_datapath.sv
// rtl/fir_datapath.sv - 16x17-bit register file executing one command per cycle
// Saturating arithmetic selected by FIR_DATAPATH_SATURATE_EN (see fir_alu).
module fir_datapath
   import fir_pkg::*;
(
   input  logic                clk,
   input  logic                n_rst,
   input  logic [2:0]          op,
   input  logic [3:0]          src1,
   input  logic [3:0]          src2,
   input  logic [3:0]          dest,
   input  logic [15:0]         ext_data1,
   input  logic [15:0]         ext_data2,
   output logic [REG_W-1:0]    outreg_data,
   output logic                overflow
);

   op_e       cmd;
   reg_idx_t  rd1_idx;
   reg_idx_t  rd2_idx;
   reg_idx_t  wr_idx;
   reg_word_t regs [NUM_REGS];
   reg_word_t alu_result;
   logic      alu_ovf;
   reg_word_t wr_data;
   logic      wr_en;

   assign cmd     = op_e'(op);
   assign rd1_idx = src1;
   assign rd2_idx = src2;
   assign wr_idx  = dest;

   fir_alu u_alu (
      .op       (cmd),
      .a        (regs[rd1_idx]),
      .b        (regs[rd2_idx]),
      .result   (alu_result),
      .overflow (alu_ovf)
   );

   always_comb begin
      wr_en   = 1'b1;
      wr_data = alu_result;
      case (cmd)
         OP_COPY:                wr_data = regs[rd1_idx];
         OP_LOAD1:               wr_data = {1'b0, ext_data1};
         OP_LOAD2:               wr_data = {1'b0, ext_data2};
         OP_ADD, OP_SUB, OP_MUL: wr_data = alu_result;
         default:                wr_en   = 1'b0;
      endcase
   end

   // Sources are read from the pre-edge array, so src==dest hazards use the old value.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
         overflow <= 1'b0;
      end else begin
         if (wr_en) begin
            regs[wr_idx] <= wr_data;
         end
         overflow <= is_arith(cmd) && alu_ovf;
      end
   end

   assign outreg_data = regs[0];

endmodule

// File: tb/tb_fir_datapath.sv
// tb/tb_fir_datapath.sv - self-checking bench with integer reference model
module tb_fir_datapath;

   logic        clk;
   logic        n_rst;
   logic [2:0]  op;
   logic [3:0]  src1;
   logic [3:0]  src2;
   logic [3:0]  dest;
   logic [15:0] ext_data1;
   logic [15:0] ext_data2;
   logic [16:0] outreg_data;
   logic        overflow;

   int checks;
   int errors;

   logic [16:0] m_regs [16];
   logic        m_ovf;

   localparam logic [2:0] NOP = 3'b000, COPY = 3'b001, LD1 = 3'b010, LD2 = 3'b011,
                          ADD = 3'b100, SUB = 3'b101, MUL = 3'b110, RSV = 3'b111;

   fir_datapath dut (
      .clk         (clk),
      .n_rst       (n_rst),
      .op          (op),
      .src1        (src1),
      .src2        (src2),
      .dest        (dest),
      .ext_data1   (ext_data1),
      .ext_data2   (ext_data2),
      .outreg_data (outreg_data),
      .overflow    (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference: exact integer result, then range check, then wrap or clamp.
   task automatic model_step(input logic [2:0] o, input logic [3:0] s1, input logic [3:0] s2,
                             input logic [3:0] d, input logic [15:0] e1, input logic [15:0] e2);
      longint a, b, t;
      logic [63:0] tb_bits;
      bit arith;
      a = $signed(m_regs[s1]);
      b = $signed(m_regs[s2]);
      t = 0;
      arith = 1'b0;
      m_ovf = 1'b0;
      case (o)
         COPY: m_regs[d] = m_regs[s1];
         LD1:  m_regs[d] = {1'b0, e1};
         LD2:  m_regs[d] = {1'b0, e2};
         ADD:  begin t = a + b; arith = 1'b1; end
         SUB:  begin t = a - b; arith = 1'b1; end
         MUL:  begin t = (a * b) >>> 15; arith = 1'b1; end
         default: ;
      endcase
      if (arith) begin
         m_ovf = (t > 65535) || (t < -65536);
         tb_bits = t;
`ifdef FIR_DATAPATH_SATURATE_EN
         if (m_ovf) m_regs[d] = (t > 0) ? 17'h0FFFF : 17'h10000;
         else       m_regs[d] = tb_bits[16:0];
`else
         m_regs[d] = tb_bits[16:0];
`endif
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_regs[i] = '0;
      m_ovf = 1'b0;
   endtask

   task automatic do_cmd(input logic [2:0] o, input logic [3:0] s1, input logic [3:0] s2,
                         input logic [3:0] d, input logic [15:0] e1, input logic [15:0] e2);
      op = o; src1 = s1; src2 = s2; dest = d; ext_data1 = e1; ext_data2 = e2;
      @(posedge clk);
      model_step(o, s1, s2, d, e1, e2);
      #1;
   endtask

   task automatic test_reset();
      n_rst = 1'b0;
      op = NOP; src1 = 0; src2 = 0; dest = 0; ext_data1 = 0; ext_data2 = 0;
      model_reset();
      #1;
      checks++;
      if (outreg_data !== 17'h0 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL reset_initial: outreg=%h ovf=%b required 00000/0", outreg_data, overflow);
      end
      @(negedge clk);
      @(negedge clk);
      n_rst = 1'b1;
   endtask

   task automatic test_loads();
      do_cmd(LD1, 0, 0, 5, 16'h1234, 16'h0);
      do_cmd(COPY, 5, 0, 0, 16'h0, 16'h0);
      checks++;
      if (outreg_data !== 17'h01234) begin
         errors++;
         $display("FAIL load_copy: outreg=%h required 01234", outreg_data);
      end
      do_cmd(LD2, 0, 0, 0, 16'h0, 16'hBEEF);
      checks++;
      if (outreg_data !== 17'h0BEEF) begin
         errors++;
         $display("FAIL load2: outreg=%h required 0beef", outreg_data);
      end
   endtask

   task automatic test_mul();
      do_cmd(LD1, 0, 0, 1, 16'h0100, 16'h0);
      do_cmd(LD2, 0, 0, 7, 16'h0, 16'h8000);
      do_cmd(MUL, 1, 7, 6, 16'h0, 16'h0);
      checks++;
      if (overflow !== 1'b0) begin
         errors++;
         $display("FAIL mul_ovf: ovf=%b required 0", overflow);
      end
      do_cmd(COPY, 6, 0, 0, 16'h0, 16'h0);
      checks++;
      if (outreg_data !== 17'h00100 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL mul_result: outreg=%h ovf=%b required 00100/0", outreg_data, overflow);
      end
   endtask

   task automatic test_add_overflow();
      logic [16:0] exp_r0;
`ifdef FIR_DATAPATH_SATURATE_EN
      exp_r0 = 17'h0FFFF;
`else
      exp_r0 = 17'h10000;
`endif
      do_cmd(LD1, 0, 0, 0, 16'hFFFF, 16'h0);
      do_cmd(LD1, 0, 0, 6, 16'h0001, 16'h0);
      do_cmd(ADD, 0, 6, 0, 16'h0, 16'h0);
      checks++;
      if (overflow !== 1'b1 || outreg_data !== exp_r0) begin
         errors++;
         $display("FAIL add_overflow: outreg=%h ovf=%b required %h/1", outreg_data, overflow, exp_r0);
      end
      do_cmd(NOP, 0, 0, 0, 16'h0, 16'h0);
      checks++;
      if (overflow !== 1'b0 || outreg_data !== exp_r0) begin
         errors++;
         $display("FAIL nop_after_ovf: outreg=%h ovf=%b required %h/0", outreg_data, overflow, exp_r0);
      end
   endtask

   task automatic test_sub_hazard();
      do_cmd(LD1, 0, 0, 0, 16'h0003, 16'h0);
      do_cmd(SUB, 0, 0, 0, 16'h0, 16'h0);
      checks++;
      if (outreg_data !== 17'h0 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL sub_hazard: outreg=%h ovf=%b required 00000/0", outreg_data, overflow);
      end
      do_cmd(RSV, 0, 0, 0, 16'h0, 16'h0);
      checks++;
      if (outreg_data !== 17'h0 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL reserved_nop: outreg=%h ovf=%b required 00000/0", outreg_data, overflow);
      end
   endtask

   task automatic test_back_to_back();
      logic [16:0] exp_v;
      bit exp_o;
      do_cmd(LD1, 0, 0, 0, 16'h0001, 16'h0);
      for (int k = 1; k <= 16; k++) begin
         do_cmd(ADD, 0, 0, 0, 16'h0, 16'h0);
         exp_o = (k == 16);
`ifdef FIR_DATAPATH_SATURATE_EN
         exp_v = (k == 16) ? 17'h0FFFF : 17'(1 << k);
`else
         exp_v = 17'(1 << k);
`endif
         checks++;
         if (outreg_data !== exp_v || overflow !== exp_o) begin
            errors++;
            $display("FAIL double_%0d: outreg=%h ovf=%b required %h/%b", k, outreg_data, overflow, exp_v, exp_o);
         end
      end
   endtask

   task automatic test_fir_sequence();
      int expected;
      logic [16:0] exp_bits;
      // delay line reg1..3 holds older samples, reg5 the new sample
      do_cmd(LD1, 0, 0, 1, 16'd100, 16'h0);
      do_cmd(LD1, 0, 0, 2, 16'd200, 16'h0);
      do_cmd(LD1, 0, 0, 3, 16'd300, 16'h0);
      do_cmd(LD2, 0, 0, 10, 16'h0, 16'h4000);
      do_cmd(LD2, 0, 0, 9,  16'h0, 16'h8000);
      do_cmd(LD2, 0, 0, 8,  16'h0, 16'h4000);
      do_cmd(LD2, 0, 0, 7,  16'h0, 16'h8000);
      do_cmd(LD1, 0, 0, 5, 16'd2, 16'h0);
      do_cmd(COPY, 3, 0, 4, 16'h0, 16'h0);
      do_cmd(COPY, 2, 0, 3, 16'h0, 16'h0);
      do_cmd(COPY, 1, 0, 2, 16'h0, 16'h0);
      do_cmd(COPY, 5, 0, 1, 16'h0, 16'h0);
      do_cmd(MUL, 1, 10, 12, 16'h0, 16'h0);
      do_cmd(MUL, 2, 9, 13, 16'h0, 16'h0);
      do_cmd(ADD, 12, 13, 12, 16'h0, 16'h0);
      do_cmd(MUL, 3, 8, 13, 16'h0, 16'h0);
      do_cmd(ADD, 12, 13, 12, 16'h0, 16'h0);
      do_cmd(MUL, 4, 7, 13, 16'h0, 16'h0);
      do_cmd(SUB, 12, 13, 12, 16'h0, 16'h0);
      checks++;
      if (overflow !== 1'b0) begin
         errors++;
         $display("FAIL fir_ovf: ovf=%b required 0", overflow);
      end
      do_cmd(COPY, 12, 0, 0, 16'h0, 16'h0);
      // 2*0.5 + 100*1.0 + 200*0.5 - 300*1.0
      expected = 1 + 100 + 100 - 300;
      exp_bits = 17'(expected);
      checks++;
      if (outreg_data !== exp_bits || overflow !== 1'b0) begin
         errors++;
         $display("FAIL fir_sum: outreg=%h ovf=%b required %h/0", outreg_data, overflow, exp_bits);
      end
   endtask

   task automatic test_random();
      logic [2:0] o;
      logic [3:0] s1, s2, d;
      for (int n = 0; n < 300; n++) begin
         o  = 3'($urandom_range(0, 7));
         s1 = 4'($urandom_range(0, 15));
         s2 = 4'($urandom_range(0, 15));
         d  = 4'($urandom_range(0, 15));
         if (n % 4 == 3) begin
            o = COPY;
            d = 4'd0;
         end
         do_cmd(o, s1, s2, d, 16'($urandom), 16'($urandom));
         checks++;
         if (outreg_data !== m_regs[0] || overflow !== m_ovf) begin
            errors++;
            $display("FAIL random_%0d op=%0d s1=%0d s2=%0d d=%0d: outreg=%h ovf=%b required %h/%b",
                     n, o, s1, s2, d, outreg_data, overflow, m_regs[0], m_ovf);
         end
      end
   endtask

   task automatic test_reset_midstream();
      do_cmd(LD1, 0, 0, 1, 16'h0001, 16'h0);
      do_cmd(LD1, 0, 0, 2, 16'hFFFF, 16'h0);
      do_cmd(LD1, 0, 0, 0, 16'h0005, 16'h0);
      do_cmd(ADD, 2, 1, 3, 16'h0, 16'h0);
      checks++;
      if (outreg_data !== 17'h00005 || overflow !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset: outreg=%h ovf=%b required 00005/1", outreg_data, overflow);
      end
      op = LD1; dest = 0; ext_data1 = 16'h7777;
      #2;
      n_rst = 1'b0;
      model_reset();
      #1;
      checks++;
      if (outreg_data !== 17'h0 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: outreg=%h ovf=%b required 00000/0", outreg_data, overflow);
      end
      @(posedge clk);
      #1;
      checks++;
      if (outreg_data !== 17'h0 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL reset_discard: outreg=%h ovf=%b required 00000/0", outreg_data, overflow);
      end
      op = LD1; src1 = 0; src2 = 0; dest = 0; ext_data1 = 16'h0042; ext_data2 = 16'h0;
      #3;
      n_rst = 1'b1;
      @(posedge clk);
      model_step(LD1, 0, 0, 0, 16'h0042, 16'h0);
      #1;
      checks++;
      if (outreg_data !== 17'h00042 || outreg_data !== m_regs[0]) begin
         errors++;
         $display("FAIL first_after_reset: outreg=%h required 00042", outreg_data);
      end
      do_cmd(COPY, 3, 0, 0, 16'h0, 16'h0);
      checks++;
      if (outreg_data !== 17'h0) begin
         errors++;
         $display("FAIL reg3_cleared: outreg=%h required 00000", outreg_data);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_loads();
      test_mul();
      test_add_overflow();
      test_sub_hazard();
      test_back_to_back();
      test_fir_sequence();
      test_random();
      test_reset_midstream();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
